// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate: AHB responder over a word-organised SRAM with programmable wait states and two-cycle ERROR
module ahb_sram_subordinate #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int ProtWidth = 4,
  parameter int MemDepth = 256,
  parameter int WaitStates = 1
) (
  input logic clk,
  input logic reset,
  input logic sel,
  input logic [AddrWidth-1:0] addr,
  input logic write,
  input logic [3:0] size,
  input logic [2:0] burst,
  input logic [ProtWidth-1:0] prot,
  input logic [2:0] trans,
  input logic mastLock,
  input logic ready,
  input logic [DataWidth-1:0] wData,
  output logic readyOut,
  output logic resp,
  output logic [DataWidth-1:0] rData
);
  localparam int Lanes = DataWidth / 8;
  localparam int Ab = $clog2(Lanes);
  localparam int IdxW = $clog2(MemDepth);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_LAST = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4;
  logic [2:0] state, nxt;
  logic [3:0] cnt;
  logic [IdxW-1:0] idx;
  logic [Ab-1:0] low, amask, lmask;
  logic [3:0] sz;
  logic wr, accept, err, open, unused;
  logic [DataWidth-1:0] mem [MemDepth];
  assign unused = ^{burst, prot, mastLock, trans[0]};
  assign accept = sel && ready && trans[1];
  assign amask = Ab'((32'd1 << size) - 32'd1);
  assign lmask = ~Ab'((32'd1 << sz) - 32'd1);
  assign err = ((addr >> Ab) >= AddrWidth'(MemDepth)) || (size > 4'(Ab)) || (|(addr[Ab-1:0] & amask));
  assign open = state == S_IDLE || state == S_LAST || state == S_ERR2;
  assign readyOut = !(state == S_WAIT || state == S_ERR1);
  assign resp = state == S_ERR1 || state == S_ERR2;
  assign rData = (state == S_LAST && !wr) ? mem[idx] : '0;
  always_comb
    nxt = open ? (accept ? (err ? S_ERR1 : (WaitStates > 0 ? S_WAIT : S_LAST)) : S_IDLE)
               : (state == S_WAIT ? (cnt == 4'd1 ? S_LAST : S_WAIT) : S_ERR2);
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      low <= '0;
      sz <= '0;
      wr <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (open && accept) ? 4'(WaitStates) : (state == S_WAIT ? cnt - 4'd1 : cnt);
      if (open && accept) begin
        idx <= addr[Ab+IdxW-1:Ab];
        low <= addr[Ab-1:0];
        sz <= size;
        wr <= write;
      end
    end
  always_ff @(posedge clk)
    if (!reset && state == S_LAST && wr)
      for (int k = 0; k < Lanes; k++)
        if (((Ab'(k) ^ low) & lmask) == '0) mem[idx][8*k +: 8] <= wData[8*k +: 8];
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// tb_ahb_sram_subordinate: vector table, corner sequences and randomized traffic against a byte-level memory model
module tb_ahb_sram_subordinate;
  logic clk = 1'b0;
  logic rst [3];
  logic sel [3];
  logic [31:0] addr [3];
  logic write [3];
  logic [3:0] size [3];
  logic [2:0] trans [3];
  logic [31:0] wdata [3];
  logic ro [3];
  logic rs [3];
  logic [31:0] rd [3];
  int ws [3] = '{1, 0, 3};
  logic [31:0] rm [3][256];
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [31:0] a;
    logic w;
    logic [3:0] sz;
    logic [31:0] wd;
    logic e;
    logic [31:0] erd;
  } vec_t;
  vec_t tbl [$];
  logic [31:0] pd [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_subordinate #(.WaitStates(g == 0 ? 1 : (g == 1 ? 0 : 3))) dut (
      .clk(clk), .reset(rst[g]), .sel(sel[g]), .addr(addr[g]), .write(write[g]), .size(size[g]),
      .burst(3'd0), .prot(4'd0), .trans(trans[g]), .mastLock(1'b0), .ready(ro[g]), .wData(wdata[g]),
      .readyOut(ro[g]), .resp(rs[g]), .rData(rd[g])
    );
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk3(input int d, input string nm, input logic o, input logic s, input logic [31:0] r);
    chk($sformatf("%s readyOut dut%0d", nm, d), {31'd0, ro[d]}, {31'd0, o});
    chk($sformatf("%s resp dut%0d", nm, d), {31'd0, rs[d]}, {31'd0, s});
    chk($sformatf("%s rData dut%0d", nm, d), rd[d], r);
  endtask
  function automatic logic merr(input logic [31:0] a, input logic [3:0] sz);
    return (a >= 32'd1024) || (sz > 4'd2) || (a % (32'd1 << sz) != 0);
  endfunction
  task automatic mwrite(input int d, input logic [31:0] a, input logic [3:0] sz, input logic [31:0] wd);
    for (int b = 0; b < (1 << sz); b++) begin
      int ba = int'(a) + b;
      rm[d][ba / 4][8 * (ba % 4) +: 8] = wd[8 * (ba % 4) +: 8];
    end
  endtask
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [3:0] sz,
                      input logic [31:0] wd, input logic e, input logic [31:0] erd);
    sel[d] = 1'b1;
    trans[d] = 3'd2;
    addr[d] = a;
    write[d] = w;
    size[d] = sz;
    @(posedge clk); #1;
    trans[d] = 3'd0;
    wdata[d] = wd;
    if (e) begin
      chk3(d, "err1", 1'b0, 1'b1, 32'd0);
      @(posedge clk); #1;
      chk3(d, "err2", 1'b1, 1'b1, 32'd0);
    end else begin
      for (int i = 0; i < ws[d]; i++) begin
        chk3(d, "wait", 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
      end
      chk3(d, "last", 1'b1, 1'b0, w ? 32'd0 : erd);
      if (w) mwrite(d, a, sz, wd);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; sel[d] = 1'b0; addr[d] = '0; write[d] = 1'b0;
      size[d] = '0; trans[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    for (int d = 0; d < 3; d++) chk3(d, "reset", 1'b1, 1'b0, 32'd0);
    tbl.push_back('{32'h10, 1'b1, 4'd2, 32'hDEADBEEF, 1'b0, 32'd0});
    tbl.push_back('{32'h10, 1'b0, 4'd2, 32'd0, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{32'h00, 1'b1, 4'd2, 32'h11111111, 1'b0, 32'd0});
    tbl.push_back('{32'h20, 1'b1, 4'd2, 32'h00000000, 1'b0, 32'd0});
    tbl.push_back('{32'h23, 1'b1, 4'd0, 32'hAA000000, 1'b0, 32'd0});
    tbl.push_back('{32'h20, 1'b1, 4'd1, 32'h00001234, 1'b0, 32'd0});
    tbl.push_back('{32'h20, 1'b0, 4'd2, 32'd0, 1'b0, 32'hAA001234});
    tbl.push_back('{32'h400, 1'b0, 4'd2, 32'd0, 1'b1, 32'd0});
    tbl.push_back('{32'h400, 1'b1, 4'd2, 32'hCAFEF00D, 1'b1, 32'd0});
    tbl.push_back('{32'h00, 1'b0, 4'd2, 32'd0, 1'b0, 32'h11111111});
    tbl.push_back('{32'h10, 1'b0, 4'd2, 32'd0, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{32'h21, 1'b1, 4'd1, 32'h0000FFFF, 1'b1, 32'd0});
    tbl.push_back('{32'h20, 1'b0, 4'd2, 32'd0, 1'b0, 32'hAA001234});
    tbl.push_back('{32'h28, 1'b1, 4'd3, 32'h55555555, 1'b1, 32'd0});
    tbl.push_back('{32'h3FC, 1'b1, 4'd2, 32'h01020304, 1'b0, 32'd0});
    tbl.push_back('{32'h3FE, 1'b1, 4'd1, 32'hBEEF0000, 1'b0, 32'd0});
    tbl.push_back('{32'h3FC, 1'b0, 4'd2, 32'd0, 1'b0, 32'hBEEF0304});
    tbl.push_back('{32'h22, 1'b0, 4'd1, 32'd0, 1'b0, 32'hAA001234});
    tbl.push_back('{32'h3FD, 1'b0, 4'd0, 32'd0, 1'b0, 32'hBEEF0304});
    foreach (tbl[i]) xfer(0, tbl[i].a, tbl[i].w, tbl[i].sz, tbl[i].wd, tbl[i].e, tbl[i].erd);
    sel[0] = 1'b0;
    trans[0] = 3'd2;
    addr[0] = 32'h10;
    @(posedge clk); #1;
    chk3(0, "unselected", 1'b1, 1'b0, 32'd0);
    trans[0] = 3'd0;
    for (int i = 0; i < 3; i++) pd[i] = $urandom;
    sel[1] = 1'b1;
    write[1] = 1'b1;
    size[1] = 4'd2;
    for (int i = 0; i < 4; i++) begin
      trans[1] = i < 3 ? 3'd2 : 3'd1;
      addr[1] = 32'(4 * i);
      if (i > 0) wdata[1] = pd[i-1];
      chk3(1, "pipe", 1'b1, 1'b0, 32'd0);
      @(posedge clk); #1;
    end
    chk3(1, "busy", 1'b1, 1'b0, 32'd0);
    trans[1] = 3'd0;
    @(posedge clk); #1;
    chk3(1, "idle", 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) mwrite(1, 32'(4 * i), 4'd2, pd[i]);
    for (int i = 0; i < 3; i++) xfer(1, 32'(4 * i), 1'b0, 4'd2, 32'd0, 1'b0, pd[i]);
    xfer(2, 32'h30, 1'b1, 4'd2, 32'h5A5A5A5A, 1'b0, 32'd0);
    sel[2] = 1'b1;
    trans[2] = 3'd2;
    addr[2] = 32'h30;
    write[2] = 1'b1;
    size[2] = 4'd2;
    @(posedge clk); #1;
    trans[2] = 3'd0;
    wdata[2] = 32'hFFFFFFFF;
    chk3(2, "abort wait1", 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk3(2, "abort wait2", 1'b0, 1'b0, 32'd0);
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk3(2, "abort reset", 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    xfer(2, 32'h30, 1'b0, 4'd2, 32'd0, 1'b0, 32'h5A5A5A5A);
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) xfer(d, 32'(4 * i), 1'b1, 4'd2, $urandom, 1'b0, 32'd0);
      for (int n = 0; n < 40; n++) begin
        logic [31:0] a;
        logic [3:0] sz;
        logic w, e;
        a = ($urandom_range(0, 7) == 0) ? 32'h400 + $urandom_range(0, 255) : 32'($urandom_range(0, 63));
        sz = 4'($urandom_range(0, 3));
        w = 1'($urandom_range(0, 1));
        e = merr(a, sz);
        xfer(d, a, w, sz, $urandom, e, e ? 32'd0 : rm[d][a[9:2]]);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
